// File: rtl/upper_char_pkg.sv
// Shared ASCII classification for the upper-case converter datapath.
// Pure constants and functions; no state, no latency, no flow control.
package upper_char_pkg;

    localparam logic [7:0] ASCII_UC_LO   = 8'h41;
    localparam logic [7:0] ASCII_UC_HI   = 8'h5A;
    localparam logic [7:0] ASCII_LC_LO   = 8'h61;
    localparam logic [7:0] ASCII_LC_HI   = 8'h7A;
    localparam logic [7:0] ASCII_CTRL_HI = 8'h1F;
    localparam logic [7:0] ASCII_DEL     = 8'h7F;

    // Bytes with bit 7 set fall above ASCII_LC_HI, so they never classify as letters.
    function automatic logic is_alpha(input logic [7:0] c);
        return ((c >= ASCII_UC_LO) && (c <= ASCII_UC_HI)) ||
               ((c >= ASCII_LC_LO) && (c <= ASCII_LC_HI));
    endfunction

    function automatic logic is_ctrl(input logic [7:0] c);
        return (c <= ASCII_CTRL_HI) || (c == ASCII_DEL);
    endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Generic synchronous FIFO: memory, wrapping pointers and occupancy level.
// Latency: write visible at rd_data one cycle after the push edge (show-ahead).
// Backpressure: push ignored when full, pop ignored when empty; no bypass path.
module sync_fifo_core #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; a push coinciding with reset is dropped so nothing
    // from the discarded stream lands in the array.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/upper_char_fifo.sv
// Output buffer for converted characters with alpha/drop statistics; optional
// control-byte filter under UPPER_FIFO_DROP_CTRL_EN. Latency: 1 cycle push-to-out_valid.
// Backpressure: in_ready from stored level only (no out_ready path); out_data held while stalled.
module upper_char_fifo
    import upper_char_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       alpha_count,
    output logic [CNT_W-1:0]       drop_count
);

    logic in_hs;
    logic store_vld;
    logic pop_vld;
    logic fifo_full;
    logic fifo_empty;

    assign in_ready  = ~fifo_full;
    assign out_valid = ~fifo_empty;
    assign in_hs     = in_valid & in_ready;
    assign pop_vld   = out_valid & out_ready;

    sync_fifo_core #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .push    (store_vld),
        .wr_data (in_data),
        .pop     (pop_vld),
        .rd_data (out_data),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            alpha_count <= '0;
        end else if (in_hs && is_alpha(in_data) && (alpha_count != '1)) begin
            alpha_count <= alpha_count + CNT_W'(1);
        end
    end

`ifdef UPPER_FIFO_DROP_CTRL_EN
    logic             drop_vld;
    logic [CNT_W-1:0] drop_cnt_q;

    // Control bytes complete the handshake but never reach the array.
    assign drop_vld   = in_hs & is_ctrl(in_data);
    assign store_vld  = in_hs & ~drop_vld;
    assign drop_count = drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop_vld && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end
`else
    assign store_vld  = in_hs;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_upper_char_fifo.sv
// Directed bench for upper_char_fifo: handshakes, full/empty edges, wrap, filter, reset.
module tb_upper_char_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int SAT_W = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [3:0]       level;
    logic [CNT_W-1:0] alpha_count;
    logic [CNT_W-1:0] drop_count;

    // Narrow-counter twin sharing the same stimulus, to reach saturation quickly.
    logic             s_in_ready;
    logic             s_out_valid;
    logic [7:0]       s_out_data;
    logic [3:0]       s_level;
    logic [SAT_W-1:0] s_alpha_count;
    logic [SAT_W-1:0] s_drop_count;

    int total = 0;
    int bad   = 0;

    upper_char_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .alpha_count (alpha_count),
        .drop_count  (drop_count)
    );

    upper_char_fifo #(.DEPTH(DEPTH), .CNT_W(SAT_W)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (s_in_ready),
        .in_data     (in_data),
        .out_valid   (s_out_valid),
        .out_ready   (out_ready),
        .out_data    (s_out_data),
        .level       (s_level),
        .alpha_count (s_alpha_count),
        .drop_count  (s_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] seq3 [3];
        logic [7:0] q [$];
        logic [7:0] exp_b;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_level", level, 0);
        check_val("rst_alpha", alpha_count, 0);
        check_val("rst_drop", drop_count, 0);
        tick();
        check_val("idle_level", level, 0);

        // Three back-to-back pushes, consumer stalled.
        seq3[0] = 8'h48; seq3[1] = 8'h41; seq3[2] = 8'h28;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = seq3[i];
            tick();
        end
        in_valid = 1'b0;
        check_val("p3_level", level, 3);
        check_val("p3_out_data", out_data, 8'h48);
        check_val("p3_alpha", alpha_count, 2);
        check_val("p3_sat_alpha", s_alpha_count, 2);
        tick();
        tick();
        check_val("p3_stall_hold", out_data, 8'h48);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_val("p3_pop_vld", out_valid, 1);
            check_val("p3_pop_data", out_data, seq3[i]);
            tick();
        end
        out_ready = 1'b0;
        check_val("p3_empty_vld", out_valid, 0);
        check_val("p3_empty_level", level, 0);

        // Fill to DEPTH, then a held 9th byte.
        in_valid = 1'b1; in_data = 8'h5A;
        for (int i = 0; i < DEPTH; i++) tick();
        check_val("full_level", level, 8);
        check_val("full_in_ready", in_ready, 0);
        in_data = 8'h47;
        tick();
        check_val("full_hold_level", level, 8);
        check_val("full_hold_alpha", alpha_count, 10);
        check_val("full_hold_data", out_data, 8'h5A);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("full_pop_level", level, 7);
        check_val("full_pop_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check_val("full_refill_level", level, 8);
        check_val("full_refill_alpha", alpha_count, 11);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_b = (i == DEPTH - 1) ? 8'h47 : 8'h5A;
            check_val("full_drain_data", out_data, exp_b);
            tick();
        end
        out_ready = 1'b0;
        check_val("full_drain_vld", out_valid, 0);

        // Steady state at level 4 with simultaneous push and pop across wraps.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h61 + 8'(i);
            q.push_back(in_data);
            tick();
        end
        check_val("ss_level_start", level, 4);
        in_data = 8'h6D; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check_val("ss_order", out_data, q[0]);
            void'(q.pop_front());
            q.push_back(8'h6D);
            tick();
            check_val("ss_level", level, 4);
        end
        in_valid = 1'b0;
        check_val("ss_alpha", alpha_count, 35);
        check_val("ss_sat_alpha", s_alpha_count, 7);
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        check_val("ss_drained", out_valid, 0);

        // Control-byte filter.
        seq3[0] = 8'h14; seq3[1] = 8'h7F; seq3[2] = 8'h30;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = seq3[i];
            tick();
        end
        in_valid = 1'b0;
`ifdef UPPER_FIFO_DROP_CTRL_EN
        check_val("flt_level", level, 1);
        check_val("flt_data", out_data, 8'h30);
        check_val("flt_drop", drop_count, 2);
`else
        check_val("flt_level", level, 3);
        check_val("flt_data", out_data, 8'h14);
        check_val("flt_drop", drop_count, 0);
`endif
        check_val("flt_alpha", alpha_count, 35);

        // High-bit byte is stored and not alphabetic.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1; in_data = 8'hC1;
        tick();
        in_valid = 1'b0;
        check_val("hi_data", out_data, 8'hC1);
        check_val("hi_alpha", alpha_count, 0);

        // Reset at level 5 with a byte in flight.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'h41 + 8'(i);
            tick();
        end
        check_val("mr_level5", level, 5);
        check_val("mr_alpha5", alpha_count, 5);
        in_data = 8'h55; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check_val("mr_level", level, 0);
        check_val("mr_out_valid", out_valid, 0);
        check_val("mr_in_ready", in_ready, 1);
        check_val("mr_alpha", alpha_count, 0);
        check_val("mr_drop", drop_count, 0);
        tick();
        check_val("mr_no_inflight", level, 0);
        in_valid = 1'b1; in_data = 8'h33;
        tick();
        in_valid = 1'b0;
        check_val("mr_first_data", out_data, 8'h33);
        check_val("mr_first_level", level, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
